// File: rtl/exe_md_stage_pkg.sv
// rtl/exe_md_stage_pkg.sv - shared encodings, bus layouts and divider states for the execute stage
package exe_md_stage_pkg;

  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTX
  } md_op_e;

  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_RSVD} mem_size_e;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  // one-hot alu_op bit positions
  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3;
  localparam int ALU_AND = 4, ALU_NOR = 5, ALU_OR = 6, ALU_XOR = 7;
  localparam int ALU_SLL = 8, ALU_SRL = 9, ALU_SRA = 10, ALU_LUI = 11;

  typedef struct packed {
    logic [11:0] alu_op;
    md_op_e      md_op;
    mem_size_e   mem_size;
    logic        load_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_8;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
  } ds_ctrl_t;

  localparam int DS_CTRL_WD = $bits(ds_ctrl_t);

  // ds bus = {ctrl, rs, rt, pc}
  function automatic int ds_to_es_bus_wd(input int dw);
    return DS_CTRL_WD + 2 * dw + 32;
  endfunction

  // es->ms bus = {res_from_mem, mem_size, addr_low, gr_we, dest, result, pc}
  function automatic int es_to_ms_bus_wd(input int dw);
    return 11 + dw + 32;
  endfunction

  // es->ds bus = {es_valid, es_busy, load_op, gr_we, dest, result}
  function automatic int es_to_ds_bus_wd(input int dw);
    return 9 + dw;
  endfunction

endpackage

// File: rtl/exe_md_stage_if.sv
// rtl/exe_md_stage_if.sv - pipeline handshake, forwarding and data SRAM signals of the execute stage
interface exe_md_stage_if
  import exe_md_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SRAM_BE_W = DATA_W / 8
);
  logic                                 ds_to_es_valid;
  logic [ds_to_es_bus_wd(DATA_W)-1:0]   ds_to_es_bus;
  logic                                 es_allowin;
  logic                                 ms_allowin;
  logic                                 es_to_ms_valid;
  logic [es_to_ms_bus_wd(DATA_W)-1:0]   es_to_ms_bus;
  logic                                 es_flush;
  logic [es_to_ds_bus_wd(DATA_W)-1:0]   es_to_ds_bus;
  logic                                 data_sram_en;
  logic [SRAM_BE_W-1:0]                 data_sram_wen;
  logic [31:0]                          data_sram_addr;
  logic [DATA_W-1:0]                    data_sram_wdata;

  modport master (
    output ds_to_es_valid, ds_to_es_bus, ms_allowin, es_flush,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  ds_to_es_valid, ds_to_es_bus, ms_allowin, es_flush,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_md_stage_md_div.sv
// rtl/exe_md_stage_md_div.sv - iterative restoring divider, DATA_W steps, first step taken on start
module md_div
  import exe_md_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic              flush,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e        state;
  logic [DATA_W-1:0] rem, quo, dvs;
  logic              neg_q, neg_r;
  logic [CNT_W-1:0]  cnt;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [2*DATA_W-1:0] first_step, next_step;

  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rm,
                                                   input logic [DATA_W-1:0] qu,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W:0] tmp;
    tmp = {rm, qu[DATA_W-1]};
    if (tmp >= {1'b0, d}) return {tmp[DATA_W-1:0] - d, qu[DATA_W-2:0], 1'b1};
    else                  return {tmp[DATA_W-1:0], qu[DATA_W-2:0], 1'b0};
  endfunction

  assign a_neg      = is_signed & a[DATA_W-1];
  assign b_neg      = is_signed & b[DATA_W-1];
  assign a_abs      = a_neg ? -a : a;
  assign b_abs      = b_neg ? -b : b;
  assign first_step = div_step('0, a_abs, b_abs);
  assign next_step  = div_step(rem, quo, dvs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DIV_IDLE;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (start && !flush) begin
          {rem, quo} <= first_step;
          dvs        <= b_abs;
          // a zero divisor keeps the raw all-ones quotient; remainder sign follows the dividend
          neg_q      <= (a_neg ^ b_neg) & (b != '0);
          neg_r      <= a_neg;
          cnt        <= CNT_W'(1);
          state      <= DIV_BUSY;
        end
        DIV_BUSY: if (flush) begin
          state <= DIV_IDLE;
        end else begin
          {rem, quo} <= next_step;
          cnt        <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) state <= DIV_DONE;
        end
        DIV_DONE: if (flush || ack) state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);
  assign q    = neg_q ? -quo : quo;
  assign r    = neg_r ? -rem : rem;

endmodule

// File: rtl/exe_md_stage.sv
// rtl/exe_md_stage.sv - execute stage: ALU, HI/LO mult/div unit, store byte-enables and wdata.
// EXE_MD_DIV_EN selects the multi-cycle divider; without it div/divu complete in one cycle with HI=LO=0.
module exe_md_stage
  import exe_md_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SRAM_BE_W = DATA_W / 8
) (
  input logic           clk,
  input logic           reset,
  exe_md_stage_if.slave io
);
  localparam int DS_WD = ds_to_es_bus_wd(DATA_W);
  localparam int SH_W  = $clog2(DATA_W);

  logic              es_valid, es_ready_go, es_allowin, es_to_ms_valid, fire, es_busy;
  logic [DS_WD-1:0]  bus_r;
  ds_ctrl_t          ctrl;
  logic [DATA_W-1:0] rs, rt, src1, src2, imm_sext, alu_result, es_result, hi, lo;
  logic [31:0]       pc;
  logic [SH_W-1:0]   sa;
  logic              is_mul, is_div;
  logic [2*DATA_W-1:0] mul_a, mul_b, product;
  logic [DATA_W-1:0] div_q, div_r;

  assign {ctrl, rs, rt, pc} = bus_r;

  assign imm_sext = {{(DATA_W-16){ctrl.imm[15]}}, ctrl.imm};
  assign src1 = ctrl.src1_is_sa  ? DATA_W'(ctrl.imm[10:6]) :
                ctrl.src1_is_pc  ? DATA_W'(pc) : rs;
  assign src2 = ctrl.src2_is_imm ? imm_sext :
                ctrl.src2_is_8   ? DATA_W'(8) : rt;
  assign sa   = src1[SH_W-1:0];

  always_comb begin
    alu_result = '0;
    if (ctrl.alu_op[ALU_ADD])  alu_result = alu_result | (src1 + src2);
    if (ctrl.alu_op[ALU_SUB])  alu_result = alu_result | (src1 - src2);
    if (ctrl.alu_op[ALU_SLT])  alu_result = alu_result | DATA_W'($signed(src1) < $signed(src2));
    if (ctrl.alu_op[ALU_SLTU]) alu_result = alu_result | DATA_W'(src1 < src2);
    if (ctrl.alu_op[ALU_AND])  alu_result = alu_result | (src1 & src2);
    if (ctrl.alu_op[ALU_NOR])  alu_result = alu_result | ~(src1 | src2);
    if (ctrl.alu_op[ALU_OR])   alu_result = alu_result | (src1 | src2);
    if (ctrl.alu_op[ALU_XOR])  alu_result = alu_result | (src1 ^ src2);
    if (ctrl.alu_op[ALU_SLL])  alu_result = alu_result | (src2 << sa);
    if (ctrl.alu_op[ALU_SRL])  alu_result = alu_result | (src2 >> sa);
    if (ctrl.alu_op[ALU_SRA])  alu_result = alu_result | DATA_W'($signed(src2) >>> sa);
    if (ctrl.alu_op[ALU_LUI])  alu_result = alu_result | {src2[DATA_W-17:0], 16'h0};
  end

  assign is_mul = (ctrl.md_op == MD_MULT) || (ctrl.md_op == MD_MULTU);
  assign is_div = (ctrl.md_op == MD_DIV)  || (ctrl.md_op == MD_DIVU);

  // a 2*DATA_W product of extended operands is exact for both signed and unsigned
  assign mul_a   = {{DATA_W{(ctrl.md_op == MD_MULT) & rs[DATA_W-1]}}, rs};
  assign mul_b   = {{DATA_W{(ctrl.md_op == MD_MULT) & rt[DATA_W-1]}}, rt};
  assign product = mul_a * mul_b;

  always_comb begin
    case (ctrl.md_op)
      MD_MFHI: es_result = hi;
      MD_MFLO: es_result = lo;
      default: es_result = alu_result;
    endcase
  end

`ifdef EXE_MD_DIV_EN
  logic div_busy, div_done;

  md_div #(.DATA_W(DATA_W)) u_md_div (
    .clk       (clk),
    .reset     (reset),
    .start     (es_valid && is_div && !io.es_flush),
    .ack       (fire),
    .flush     (io.es_flush),
    .is_signed (ctrl.md_op == MD_DIV),
    .a         (rs),
    .b         (rt),
    .busy      (div_busy),
    .done      (div_done),
    .q         (div_q),
    .r         (div_r)
  );

  assign es_ready_go = is_div ? div_done : 1'b1;
  assign es_busy     = div_busy;
`else
  assign div_q       = '0;
  assign div_r       = '0;
  assign es_ready_go = 1'b1;
  assign es_busy     = 1'b0;
`endif

  assign es_to_ms_valid = es_valid && es_ready_go && !io.es_flush;
  assign es_allowin     = !es_valid || (es_ready_go && io.ms_allowin);
  assign fire           = es_to_ms_valid && io.ms_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
      bus_r    <= '0;
    end else begin
      if (io.es_flush)     es_valid <= 1'b0;
      else if (es_allowin) es_valid <= io.ds_to_es_valid;
      if (io.ds_to_es_valid && es_allowin) bus_r <= io.ds_to_es_bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (fire) begin
      if (is_mul) {hi, lo} <= product;
      if (is_div) begin
        hi <= div_r;
        lo <= div_q;
      end
      if (ctrl.md_op == MD_MTX) begin
        if (ctrl.imm[0]) hi <= rs;
        else             lo <= rs;
      end
    end
  end

  always_comb begin
    io.data_sram_wen = '0;
    if (fire && ctrl.mem_we) begin
      case (ctrl.mem_size)
        MEM_BYTE: io.data_sram_wen = SRAM_BE_W'(1) << alu_result[1:0];
        MEM_HALF: if (!alu_result[0])       io.data_sram_wen = SRAM_BE_W'(3) << {alu_result[1], 1'b0};
        default:  if (alu_result[1:0] == 2'b00) io.data_sram_wen = '1;
      endcase
    end
  end

  always_comb begin
    case (ctrl.mem_size)
      MEM_BYTE: io.data_sram_wdata = {(DATA_W/8){rt[7:0]}};
      MEM_HALF: io.data_sram_wdata = {(DATA_W/16){rt[15:0]}};
      default:  io.data_sram_wdata = rt;
    endcase
  end

  assign io.data_sram_en   = 1'b1;
  assign io.data_sram_addr = alu_result[31:0];
  assign io.es_allowin     = es_allowin;
  assign io.es_to_ms_valid = es_to_ms_valid;
  assign io.es_to_ms_bus   = {ctrl.load_op, ctrl.mem_size, alu_result[1:0], ctrl.gr_we,
                              ctrl.dest, es_result, pc};
  assign io.es_to_ds_bus   = {es_valid, es_busy, ctrl.load_op, ctrl.gr_we, ctrl.dest, es_result};

endmodule

// File: tb/tb_exe_md_stage.sv
// tb/tb_exe_md_stage.sv - directed self-checking bench for exe_md_stage (divider tests follow EXE_MD_DIV_EN)
module tb_exe_md_stage;
  import exe_md_stage_pkg::*;

  localparam int DW     = 32;
  localparam int BUS_WD = ds_to_es_bus_wd(DW);

  localparam logic [11:0] OP_NONE = 12'h000;
  localparam logic [11:0] OP_ADD  = 12'h001 << ALU_ADD;
  localparam logic [11:0] OP_SUB  = 12'h001 << ALU_SUB;
  localparam logic [11:0] OP_SLT  = 12'h001 << ALU_SLT;
  localparam logic [11:0] OP_SLTU = 12'h001 << ALU_SLTU;
  localparam logic [11:0] OP_NOR  = 12'h001 << ALU_NOR;
  localparam logic [11:0] OP_SLL  = 12'h001 << ALU_SLL;
  localparam logic [11:0] OP_SRA  = 12'h001 << ALU_SRA;
  localparam logic [11:0] OP_LUI  = 12'h001 << ALU_LUI;

  // flags = {load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we}
  localparam logic [6:0] F_NONE = 7'h00, F_MWE = 7'h01, F_GWE = 7'h02, F_S8 = 7'h04;
  localparam logic [6:0] F_IMM  = 7'h08, F_PC  = 7'h10, F_SA  = 7'h20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  exe_md_stage_if #(.DATA_W(DW)) bif ();

  exe_md_stage #(.DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bif.slave)
  );

  always #5 clk = ~clk;

  wire [31:0] ms_res = bif.es_to_ms_bus[63:32];
  wire        es_v   = bif.es_to_ds_bus[40];
  wire        es_bsy = bif.es_to_ds_bus[39];

  function automatic logic [BUS_WD-1:0] mk(input logic [11:0] alu, input md_op_e md,
      input mem_size_e sz, input logic [6:0] fl, input logic [15:0] imm,
      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc);
    ds_ctrl_t c;
    c.alu_op = alu;  c.md_op = md;  c.mem_size = sz;
    {c.load_op, c.src1_is_sa, c.src1_is_pc, c.src2_is_imm, c.src2_is_8, c.gr_we, c.mem_we} = fl;
    c.dest = 5'd2;  c.imm = imm;
    return {c, rs, rt, pc};
  endfunction

  task automatic drive(input logic [BUS_WD-1:0] b);
    bif.ds_to_es_valid = 1'b1;
    bif.ds_to_es_bus   = b;
  endtask

  task automatic idle();
    bif.ds_to_es_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (bif.es_to_ms_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bif.es_to_ms_valid); else pass_cnt++;
    total_cnt++; if (bif.es_allowin !== 1'b1) $display("FAIL reset_allowin: got %b want 1", bif.es_allowin); else pass_cnt++;
    total_cnt++; if (es_bsy !== 1'b0 || es_v !== 1'b0) $display("FAIL reset_busy_valid: got %b%b want 00", es_bsy, es_v); else pass_cnt++;
    total_cnt++; if (bif.data_sram_wen !== 4'h0 || bif.data_sram_en !== 1'b1) $display("FAIL reset_sram: wen=%h en=%b want 0/1", bif.data_sram_wen, bif.data_sram_en); else pass_cnt++;
    reset = 1'b0;
    drive(mk(OP_NONE, MD_MFHI, MEM_WORD, F_GWE, 16'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    total_cnt++; if (ms_res !== 32'h0) $display("FAIL reset_hi: got %h want 0", ms_res); else pass_cnt++;
    drive(mk(OP_NONE, MD_MFLO, MEM_WORD, F_GWE, 16'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    total_cnt++; if (ms_res !== 32'h0) $display("FAIL reset_lo: got %h want 0", ms_res); else pass_cnt++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_addiu();
    drive(mk(OP_ADD, MD_NONE, MEM_WORD, F_IMM | F_GWE, 16'hFFFF, 32'd5, 32'd0, 32'h100));
    @(negedge clk);
    idle();
    total_cnt++; if (bif.es_to_ms_valid !== 1'b1 || ms_res !== 32'd4) $display("FAIL addiu: valid=%b result=%h want 1/4", bif.es_to_ms_valid, ms_res); else pass_cnt++;
    total_cnt++; if (bif.es_allowin !== 1'b1 || bif.data_sram_addr !== 32'd4) $display("FAIL addiu_nostall: allowin=%b addr=%h want 1/4", bif.es_allowin, bif.data_sram_addr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bif.es_to_ms_valid !== 1'b0) $display("FAIL addiu_drain: got %b want 0", bif.es_to_ms_valid); else pass_cnt++;
  endtask

  task automatic test_alu();
    logic [11:0] op[8]  = '{OP_SUB, OP_SLT, OP_SLTU, OP_SLL, OP_SRA, OP_LUI, OP_ADD, OP_NOR};
    logic [6:0]  fl[8]  = '{F_GWE, F_GWE, F_GWE, F_SA | F_GWE, F_SA | F_GWE, F_IMM | F_GWE, F_PC | F_S8 | F_GWE, F_GWE};
    logic [15:0] imm[8] = '{16'h0, 16'h0, 16'h0, 16'h0100, 16'h0100, 16'h1234, 16'h0, 16'h0};
    logic [31:0] rs[8]  = '{32'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0F0F0000};
    logic [31:0] rt[8]  = '{32'd3, 32'd1, 32'd1, 32'd1, 32'h80000000, 32'h0, 32'h0, 32'h00FF00FF};
    logic [31:0] exp[8] = '{32'd7, 32'd1, 32'd0, 32'd16, 32'hF8000000, 32'h12340000, 32'hBFC00008, 32'hF000FF00};
    for (int i = 0; i < 8; i++) begin
      drive(mk(op[i], MD_NONE, MEM_WORD, fl[i], imm[i], rs[i], rt[i], 32'hBFC00000));
      @(negedge clk);
      total_cnt++; if (bif.es_to_ms_valid !== 1'b1 || ms_res !== exp[i]) $display("FAIL alu_%0d: valid=%b result=%h want 1/%h", i, bif.es_to_ms_valid, ms_res, exp[i]); else pass_cnt++;
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back_md();
    md_op_e      md[10]  = '{MD_MULT, MD_MFHI, MD_MFLO, MD_MULTU, MD_MFHI, MD_MFLO, MD_MTX, MD_MTX, MD_MFHI, MD_MFLO};
    logic [15:0] imm[10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1, 16'h0, 16'h0, 16'h0};
    logic [31:0] rs[10]  = '{32'hFFFFFFFD, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h55, 32'hAA, 32'h0, 32'h0};
    logic [31:0] rt[10]  = '{32'd5, 32'h0, 32'h0, 32'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp[10] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h0, 32'h1, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h55, 32'hAA};
    logic        chk[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(mk(OP_NONE, md[i], MEM_WORD, F_GWE, imm[i], rs[i], rt[i], 32'h0));
      @(negedge clk);
      if (chk[i]) begin
        total_cnt++; if (bif.es_to_ms_valid !== 1'b1 || ms_res !== exp[i]) $display("FAIL md_%0d: valid=%b result=%h want 1/%h", i, bif.es_to_ms_valid, ms_res, exp[i]); else pass_cnt++;
      end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_store();
    mem_size_e   sz[5]  = '{MEM_HALF, MEM_HALF, MEM_WORD, MEM_WORD, MEM_BYTE};
    logic [15:0] imm[5] = '{16'h2002, 16'h2001, 16'h2004, 16'h2002, 16'h2001};
    logic [31:0] rt[5]  = '{32'h1234, 32'h1234, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5A};
    logic [3:0]  wen[5] = '{4'b1100, 4'b0000, 4'b1111, 4'b0000, 4'b0010};
    logic [31:0] wd[5]  = '{32'h12341234, 32'h12341234, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5A5A5A5A};
    bif.ms_allowin = 1'b0;
    drive(mk(OP_ADD, MD_NONE, MEM_BYTE, F_IMM | F_MWE, 16'h0003, 32'h1000, 32'hAB, 32'h0));
    @(negedge clk);
    idle();
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (bif.data_sram_wen !== 4'h0 || bif.es_to_ms_valid !== 1'b1) $display("FAIL sb_stall_%0d: wen=%b valid=%b want 0000/1", i, bif.data_sram_wen, bif.es_to_ms_valid); else pass_cnt++;
      @(negedge clk);
    end
    bif.ms_allowin = 1'b1;
    #1;
    total_cnt++; if (bif.data_sram_wen !== 4'b1000 || bif.data_sram_wdata !== 32'hABABABAB || bif.data_sram_addr !== 32'h1003) $display("FAIL sb_fire: wen=%b wdata=%h addr=%h want 1000/ababab ab/1003", bif.data_sram_wen, bif.data_sram_wdata, bif.data_sram_addr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bif.data_sram_wen !== 4'h0) $display("FAIL sb_once: wen=%b want 0000", bif.data_sram_wen); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      drive(mk(OP_ADD, MD_NONE, sz[i], F_IMM | F_MWE, imm[i], 32'h0, rt[i], 32'h0));
      @(negedge clk);
      total_cnt++; if (bif.data_sram_wen !== wen[i] || bif.data_sram_wdata !== wd[i]) $display("FAIL store_%0d: wen=%b wdata=%h want %b/%h", i, bif.data_sram_wen, bif.data_sram_wdata, wen[i], wd[i]); else pass_cnt++;
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_flush();
    drive(mk(OP_ADD, MD_NONE, MEM_WORD, F_IMM | F_MWE, 16'h3000, 32'h0, 32'h1, 32'h0));
    @(negedge clk);
    idle();
    bif.es_flush = 1'b1;
    #1;
    total_cnt++; if (bif.data_sram_wen !== 4'h0 || bif.es_to_ms_valid !== 1'b0) $display("FAIL flush_store: wen=%b valid=%b want 0000/0", bif.data_sram_wen, bif.es_to_ms_valid); else pass_cnt++;
    @(negedge clk);
    bif.es_flush = 1'b0;
    total_cnt++; if (es_v !== 1'b0) $display("FAIL flush_es_valid: got %b want 0", es_v); else pass_cnt++;
    drive(mk(OP_NONE, MD_MULT, MEM_WORD, F_NONE, 16'h0, 32'd2, 32'd3, 32'h0));
    @(negedge clk);
    idle();
    bif.es_flush = 1'b1;
    @(negedge clk);
    bif.es_flush = 1'b0;
    drive(mk(OP_NONE, MD_MFHI, MEM_WORD, F_GWE, 16'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    total_cnt++; if (ms_res !== 32'h55) $display("FAIL flush_hi_kept: got %h want 00000055", ms_res); else pass_cnt++;
    drive(mk(OP_NONE, MD_MFLO, MEM_WORD, F_GWE, 16'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    total_cnt++; if (ms_res !== 32'hAA) $display("FAIL flush_lo_kept: got %h want 000000aa", ms_res); else pass_cnt++;
    idle();
    @(negedge clk);
  endtask

`ifdef EXE_MD_DIV_EN
  task automatic run_div(input string nm, input md_op_e md, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int   low = 0;
    logic busy_seen = 1'b0;
    drive(mk(OP_NONE, md, MEM_WORD, F_NONE, 16'h0, a, b, 32'h0));
    @(negedge clk);
    idle();
    while (bif.es_to_ms_valid !== 1'b1 && low < 100) begin
      if (es_bsy === 1'b1) busy_seen = 1'b1;
      low++;
      @(negedge clk);
    end
    total_cnt++; if (low !== 32 || !busy_seen) $display("FAIL %s_latency: stall cycles=%0d busy_seen=%b want 32/1", nm, low, busy_seen); else pass_cnt++;
    drive(mk(OP_NONE, MD_MFLO, MEM_WORD, F_GWE, 16'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    total_cnt++; if (ms_res !== exp_lo) $display("FAIL %s_lo: got %h want %h", nm, ms_res, exp_lo); else pass_cnt++;
    drive(mk(OP_NONE, MD_MFHI, MEM_WORD, F_GWE, 16'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    total_cnt++; if (ms_res !== exp_hi) $display("FAIL %s_hi: got %h want %h", nm, ms_res, exp_hi); else pass_cnt++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_div();
    run_div("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu_zero", MD_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9);
    drive(mk(OP_NONE, MD_DIV, MEM_WORD, F_NONE, 16'h0, 32'd100, 32'd7, 32'h0));
    @(negedge clk);
    idle();
    repeat (9) @(negedge clk);
    bif.es_flush = 1'b1;
    @(negedge clk);
    bif.es_flush = 1'b0;
    total_cnt++; if (es_v !== 1'b0 || es_bsy !== 1'b0) $display("FAIL div_flush: es_valid=%b busy=%b want 0/0", es_v, es_bsy); else pass_cnt++;
    run_div("divu_after_flush", MD_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
    drive(mk(OP_NONE, MD_DIV, MEM_WORD, F_NONE, 16'h0, 32'd50, 32'd3, 32'h0));
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (bif.es_to_ms_valid !== 1'b0 || es_bsy !== 1'b0 || es_v !== 1'b0 || bif.es_allowin !== 1'b1) $display("FAIL div_async_reset: valid=%b busy=%b es_valid=%b allowin=%b want 0/0/0/1", bif.es_to_ms_valid, es_bsy, es_v, bif.es_allowin); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    run_div("divu_after_reset", MD_DIVU, 32'd10, 32'd3, 32'd3, 32'd1);
  endtask
`else
  task automatic test_div();
    drive(mk(OP_NONE, MD_DIV, MEM_WORD, F_NONE, 16'h0, 32'hFFFFFFF9, 32'd2, 32'h0));
    @(negedge clk);
    total_cnt++; if (bif.es_to_ms_valid !== 1'b1 || es_bsy !== 1'b0) $display("FAIL div_onecycle: valid=%b busy=%b want 1/0", bif.es_to_ms_valid, es_bsy); else pass_cnt++;
    drive(mk(OP_NONE, MD_MFLO, MEM_WORD, F_GWE, 16'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    total_cnt++; if (ms_res !== 32'h0) $display("FAIL div_lo_zero: got %h want 0", ms_res); else pass_cnt++;
    drive(mk(OP_NONE, MD_MFHI, MEM_WORD, F_GWE, 16'h0, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    total_cnt++; if (ms_res !== 32'h0) $display("FAIL div_hi_zero: got %h want 0", ms_res); else pass_cnt++;
    bif.ms_allowin = 1'b0;
    drive(mk(OP_ADD, MD_NONE, MEM_WORD, F_IMM | F_GWE, 16'h0001, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    idle();
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (bif.es_to_ms_valid !== 1'b0 || es_v !== 1'b0 || bif.es_allowin !== 1'b1) $display("FAIL async_reset: valid=%b es_valid=%b allowin=%b want 0/0/1", bif.es_to_ms_valid, es_v, bif.es_allowin); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    bif.ms_allowin = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    bif.ds_to_es_valid = 1'b0;
    bif.ds_to_es_bus   = '0;
    bif.ms_allowin     = 1'b1;
    bif.es_flush       = 1'b0;
    test_reset();
    test_addiu();
    test_alu();
    test_back_to_back_md();
    test_store();
    test_flush();
    test_div();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
